alu_share_arbiter: RTL and testbench

Shares one 32-bit ALU instance between two requesters, e.g. the EXE-stage path and a multi-cycle helper unit. It arbitrates requests round-robin and latches operands and command. The ALU evaluates for one cycle, and the result is held in a register until the granted requester accepts it. Every transaction uses a valid/ready handshake, so either side can stall.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_share_arbiter_if.sv | 42 ++++
 rtl/alu_share_arbiter_alu.sv | 29 ++
 rtl/alu_share_arbiter.sv | 110 +++++++++++
 tb/tb_alu_share_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: widths, ALU command
// encodings, FSM state encoding and the supported-command check.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;

    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AND = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_OR  = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_NOR = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_XOR = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_SLA = 4'b1000;
    localparam logic [CMD_W-1:0] CMD_SRA = 4'b1001;
    localparam logic [CMD_W-1:0] CMD_SRL = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // True when the command is one the ALU actually implements
    function automatic logic cmd_is_valid(input logic [CMD_W-1:0] cmd);
        logic ok;
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_NOR,
            CMD_XOR, CMD_SLA, CMD_SRA, CMD_SRL: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for the two requesters sharing one ALU.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if;
    import alu_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_val1;
    logic [DATA_W-1:0] req0_val2;
    logic [CMD_W-1:0]  req0_cmd;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_val1;
    logic [DATA_W-1:0] req1_val2;
    logic [CMD_W-1:0]  req1_cmd;

    logic              resp0_valid;
    logic              resp0_ready;
    logic              resp1_valid;
    logic              resp1_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              busy;

    modport master (
        output req0_valid, req0_val1, req0_val2, req0_cmd,
        output req1_valid, req1_val1, req1_val2, req1_cmd,
        output resp0_ready, resp1_ready,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
        input  resp_data, resp_err, busy
    );

    modport slave (
        input  req0_valid, req0_val1, req0_val2, req0_cmd,
        input  req1_valid, req1_val1, req1_val2, req1_cmd,
        input  resp0_ready, resp1_ready,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
        output resp_data, resp_err, busy
    );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Purely combinational 32-bit ALU. Unsupported commands produce zero.
// Shift amounts use the full 32-bit val2, so shifts of 32 or more saturate.
module alu_share_arbiter_alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_val1,
    input  logic [DATA_W-1:0] i_val2,
    input  logic [CMD_W-1:0]  i_cmd,
    output logic [DATA_W-1:0] o_result
);

    // Select the operation named by the command; zero for anything unknown
    always_comb begin
        o_result = '0;
        case (i_cmd)
            CMD_ADD: o_result = i_val1 + i_val2;
            CMD_SUB: o_result = i_val1 - i_val2;
            CMD_AND: o_result = i_val1 & i_val2;
            CMD_OR:  o_result = i_val1 | i_val2;
            CMD_NOR: o_result = ~(i_val1 | i_val2);
            CMD_XOR: o_result = i_val1 ^ i_val2;
            CMD_SLA: o_result = i_val1 << i_val2;
            CMD_SRA: o_result = $signed(i_val1) >>> i_val2;
            CMD_SRL: o_result = i_val1 >> i_val2;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// IDLE accepts one request, EXEC evaluates the latched operands for one
// cycle, RESP holds the registered result until the winner takes it.
module alu_share_arbiter
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus
);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_lastGrant;
    logic              r_id;
    logic [DATA_W-1:0] r_val1;
    logic [DATA_W-1:0] r_val2;
    logic [CMD_W-1:0]  r_cmd;
    logic [DATA_W-1:0] r_respData;
    logic              r_respErr;

    logic              w_anyValid;
    logic              w_grantId;
    logic              w_accept;
    logic              w_respTaken;
    logic [DATA_W-1:0] w_aluResult;

    alu_share_arbiter_alu u_alu (
        .i_val1   (r_val1),
        .i_val2   (r_val2),
        .i_cmd    (r_cmd),
        .o_result (w_aluResult)
    );

    // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last
    always_comb begin
        w_anyValid  = bus.req0_valid | bus.req1_valid;
        w_grantId   = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grantId = ~r_lastGrant;
        end else if (bus.req1_valid) begin
            w_grantId = 1'b1;
        end
        w_accept    = (r_state == IDLE) && w_anyValid && rst;
        w_respTaken = r_id ? bus.resp1_ready : bus.resp0_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: accept, evaluate for exactly one cycle, wait for the winner
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyValid) w_nextState = EXEC;
            EXEC:    w_nextState = RESP;
            RESP:    if (w_respTaken) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs: ready only in IDLE to the winner, valid only in RESP to the owner
    always_comb begin
        bus.req0_ready  = w_accept && !w_grantId;
        bus.req1_ready  = w_accept &&  w_grantId;
        bus.resp0_valid = (r_state == RESP) && !r_id;
        bus.resp1_valid = (r_state == RESP) &&  r_id;
        bus.busy        = (r_state != IDLE);
        bus.resp_data   = r_respData;
        bus.resp_err    = r_respErr;
    end

    // Operand latch on accept, result capture at the end of EXEC
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lastGrant <= 1'b1;
            r_id        <= 1'b0;
            r_val1      <= '0;
            r_val2      <= '0;
            r_cmd       <= '0;
            r_respData  <= '0;
            r_respErr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyValid) begin
                        r_id        <= w_grantId;
                        r_lastGrant <= w_grantId;
                        r_val1      <= w_grantId ? bus.req1_val1 : bus.req0_val1;
                        r_val2      <= w_grantId ? bus.req1_val2 : bus.req0_val2;
                        r_cmd       <= w_grantId ? bus.req1_cmd  : bus.req0_cmd;
                    end
                end
                EXEC: begin
                    r_respData <= w_aluResult;
                    r_respErr  <= ~cmd_is_valid(r_cmd);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed cases plus randomized
// rounds compared against a behavioural model of arbitration and the ALU.
module tb_alu_share_arbiter;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lastGrant;

    alu_share_arbiter_if bus ();

    alu_share_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run did not complete (actual timeout, required finish)");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] aluRef(input op_t op);
        logic [31:0] r;
        r = 32'd0;
        case (op.cmd)
            4'd0:  r = op.a + op.b;
            4'd2:  r = op.a - op.b;
            4'd4:  r = op.a & op.b;
            4'd5:  r = op.a | op.b;
            4'd6:  r = ~(op.a | op.b);
            4'd7:  r = op.a ^ op.b;
            4'd8: begin
                r = op.a;
                for (int i = 0; i < 33 && i < op.b; i++) r = r * 2;
            end
            4'd9: begin
                r = op.a;
                for (int i = 0; i < 33 && i < op.b; i++) r = {r[31], r[31:1]};
            end
            4'd10: begin
                r = op.a;
                for (int i = 0; i < 33 && i < op.b; i++) r = r / 2;
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic errRef(input logic [3:0] cmd);
        return !(cmd inside {4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10});
    endfunction

    task automatic driveReq(input int id, input bit v, input op_t op);
        if (id == 0) begin
            bus.req0_valid = v;
            bus.req0_val1  = op.a;
            bus.req0_val2  = op.b;
            bus.req0_cmd   = op.cmd;
        end else begin
            bus.req1_valid = v;
            bus.req1_val1  = op.a;
            bus.req1_val2  = op.b;
            bus.req1_cmd   = op.cmd;
        end
    endtask

    task automatic setRespReady(input int id, input bit v);
        if (id == 0) bus.resp0_ready = v;
        else         bus.resp1_ready = v;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_req0_ready"}, bus.req0_ready, 0);
        checkOutput({tag, "_req1_ready"}, bus.req1_ready, 0);
        checkOutput({tag, "_resp0_valid"}, bus.resp0_valid, 0);
        checkOutput({tag, "_resp1_valid"}, bus.resp1_valid, 0);
    endtask

    // Called at a negedge with the DUT idle; serves every requested op in model order
    task automatic applyStimulus(input bit use0, input bit use1, input op_t op0, input op_t op1,
                                 input int stall0, input int stall1);
        bit          pend[2];
        op_t         ops[2];
        int          st[2];
        int          g;
        logic [31:0] expData;
        logic        expErr;
        pend[0] = use0; pend[1] = use1;
        ops[0]  = op0;  ops[1]  = op1;
        st[0]   = stall0; st[1] = stall1;
        if (use0) driveReq(0, 1'b1, op0);
        if (use1) driveReq(1, 1'b1, op1);
        while (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) g = (lastGrant == 1) ? 0 : 1;
            else                    g = pend[0] ? 0 : 1;
            #1;
            checkOutput("grant_req0_ready", bus.req0_ready, (g == 0));
            checkOutput("grant_req1_ready", bus.req1_ready, (g == 1));
            checkOutput("idle_busy", bus.busy, 0);
            lastGrant = g;
            expData   = aluRef(ops[g]);
            expErr    = errRef(ops[g].cmd);
            @(posedge clk);
            @(negedge clk);
            driveReq(g, 1'b0, ops[g]);
            pend[g] = 1'b0;
            setRespReady(g, st[g] == 0);
            setRespReady(1 - g, 1'($urandom_range(0, 1)));
            #1;
            checkOutput("exec_busy", bus.busy, 1);
            checkQuiet("exec");
            @(posedge clk);
            @(negedge clk);
            checkOutput("resp_valid_own", (g == 0) ? bus.resp0_valid : bus.resp1_valid, 1);
            checkOutput("resp_valid_other", (g == 0) ? bus.resp1_valid : bus.resp0_valid, 0);
            checkOutput("resp_data", bus.resp_data, expData);
            checkOutput("resp_err", bus.resp_err, expErr);
            checkOutput("resp_ready_blocked", bus.req0_ready | bus.req1_ready, 0);
            for (int k = 0; k < st[g]; k++) begin
                @(posedge clk);
                @(negedge clk);
                checkOutput("stall_valid", (g == 0) ? bus.resp0_valid : bus.resp1_valid, 1);
                checkOutput("stall_data", bus.resp_data, expData);
                checkOutput("stall_err", bus.resp_err, expErr);
                checkOutput("stall_busy", bus.busy, 1);
                checkOutput("stall_ready_blocked", bus.req0_ready | bus.req1_ready, 0);
                if (k == st[g] - 1) setRespReady(g, 1'b1);
            end
            @(posedge clk);
            @(negedge clk);
            setRespReady(0, 1'b0);
            setRespReady(1, 1'b0);
            #1;
            checkOutput("back_idle_busy", bus.busy, 0);
            checkOutput("back_idle_resp", bus.resp0_valid | bus.resp1_valid, 0);
        end
    endtask

    // Resets the DUT while a req0 op sits in EXEC (phase 1) or RESP (phase 2)
    task automatic resetDuring(input int phase);
        op_t op;
        op.cmd = 4'd0; op.a = 32'd1; op.b = 32'd2;
        driveReq(0, 1'b1, op);
        #1;
        checkOutput("rst_pre_grant", bus.req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        driveReq(0, 1'b0, op);
        bus.resp0_ready = 1'b0;
        if (phase == 2) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rst_pre_resp", bus.resp0_valid, 1);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        lastGrant = 1;
        #1;
        checkQuiet("after_rst");
        checkOutput("after_rst_data", bus.resp_data, 0);
        checkOutput("after_rst_err", bus.resp_err, 0);
        checkOutput("after_rst_busy", bus.busy, 0);
        bus.resp0_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("no_late_resp", bus.resp0_valid | bus.resp1_valid, 0);
            checkOutput("no_late_busy", bus.busy, 0);
        end
        bus.resp0_ready = 1'b0;
    endtask

    function automatic op_t mkOp(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.cmd = cmd; o.a = a; o.b = b;
        return o;
    endfunction

    initial begin
        op_t o0;
        op_t o1;
        checks    = 0;
        errors    = 0;
        lastGrant = 1;
        rst       = 1'b0;
        o0        = mkOp(4'd0, 32'd0, 32'd0);
        driveReq(0, 1'b0, o0);
        driveReq(1, 1'b0, o0);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkQuiet("reset");
        checkOutput("reset_data", bus.resp_data, 0);
        checkOutput("reset_err", bus.resp_err, 0);
        checkOutput("reset_busy", bus.busy, 0);
        @(negedge clk);

        $display("[TB] ADD single requester");
        applyStimulus(1'b1, 1'b0, mkOp(4'd0, 32'd5, 32'd3), o0, 0, 0);

        $display("[TB] tie SUB / SRA, twice");
        o0 = mkOp(4'd2, 32'd10, 32'd3);
        o1 = mkOp(4'd9, 32'h8000_0000, 32'd4);
        applyStimulus(1'b1, 1'b1, o0, o1, 0, 0);
        applyStimulus(1'b1, 1'b1, o0, o1, 1, 0);

        $display("[TB] unsupported command");
        applyStimulus(1'b0, 1'b1, o0, mkOp(4'd1, 32'h0000_FFFF, 32'd1), 0, 0);

        $display("[TB] backpressure with waiting req1");
        applyStimulus(1'b1, 1'b1, mkOp(4'd4, 32'h0000_F0F0, 32'h0000_FF00),
                      mkOp(4'd7, 32'h1234_5678, 32'hFFFF_0000), 5, 0);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 40; r++) begin
            bit u0;
            bit u1;
            u0 = 1'($urandom_range(0, 1));
            u1 = 1'($urandom_range(0, 1));
            if (!u0 && !u1) u0 = 1'b1;
            o0 = mkOp(4'($urandom_range(0, 15)), $urandom,
                      ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)));
            o1 = mkOp(4'($urandom_range(0, 15)), $urandom,
                      ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)));
            applyStimulus(u0, u1, o0, o1, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] reset in EXEC");
        resetDuring(1);
        $display("[TB] reset in RESP, then tie");
        resetDuring(2);
        applyStimulus(1'b1, 1'b1, mkOp(4'd10, 32'hF000_0000, 32'd8),
                      mkOp(4'd8, 32'd3, 32'd2), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
